// File: rtl/booth_seq_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM states,
// recoded digit fields and the recoding helper.
package booth_seq_pkg;

  localparam int BOOTH_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } booth_state_t;

  // Digit magnitude is one (1) or two (2); neg flips the sign.
  typedef struct packed {
    logic one;
    logic two;
    logic neg;
  } booth_digit_t;

  function automatic booth_digit_t booth_recode(input logic [2:0] bits);
    booth_digit_t d;
    case (bits)
      3'b000:  d = '{one: 1'b0, two: 1'b0, neg: 1'b0};
      3'b001:  d = '{one: 1'b1, two: 1'b0, neg: 1'b0};
      3'b010:  d = '{one: 1'b1, two: 1'b0, neg: 1'b0};
      3'b011:  d = '{one: 1'b0, two: 1'b1, neg: 1'b0};
      3'b100:  d = '{one: 1'b0, two: 1'b1, neg: 1'b1};
      3'b101:  d = '{one: 1'b1, two: 1'b0, neg: 1'b1};
      3'b110:  d = '{one: 1'b1, two: 1'b0, neg: 1'b1};
      3'b111:  d = '{one: 1'b0, two: 1'b0, neg: 1'b0};
      default: d = '{one: 1'b0, two: 1'b0, neg: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_digit_pp.sv
// Combinational radix-4 Booth partial product: digit(y triplet) * x,
// WIDTH+2 bits so that -2 * -2^(WIDTH-1) still fits.
module booth_digit_pp
  import booth_seq_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH_DEF
) (
  input  logic [2:0]       i_y3,
  input  logic [WIDTH-1:0] i_x,
  output logic [WIDTH+1:0] o_pp
);

  booth_digit_t     w_dig;
  logic [WIDTH+1:0] w_xe;
  logic [WIDTH+1:0] w_mag;

  // Select |digit| * x, then apply the digit sign.
  always_comb begin
    w_dig = booth_recode(i_y3);
    w_xe  = {{2{i_x[WIDTH-1]}}, i_x};
    if (w_dig.two) begin
      w_mag = w_xe << 1;
    end else if (w_dig.one) begin
      w_mag = w_xe;
    end else begin
      w_mag = '0;
    end
    if (w_dig.neg) begin
      o_pp = -w_mag;
    end else begin
      o_pp = w_mag;
    end
  end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-4 Booth multiplier, one digit per cycle, valid/ready on both sides.
// Optional macro BOOTH_SEQ_ZERO_SKIP_EN ends RUN early once remaining digits are all zero.
module booth_seq_ctrl
  import booth_seq_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

  localparam int NDIG = WIDTH / 2;
  localparam int CW   = $clog2(NDIG) + 1;

  booth_state_t       r_state;
  booth_state_t       w_next;
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_y;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_p;
  logic [CW-1:0]      r_cnt;

  logic signed [WIDTH:0] w_yext;
  logic signed [WIDTH:0] w_ysh;
  logic [WIDTH+1:0]      w_pp;
  logic [2*WIDTH-1:0]    w_pp_ext;
  logic [2*WIDTH-1:0]    w_pp_sh;
  logic [2*WIDTH-1:0]    w_sum;
  logic                  w_last;
  logic                  w_skip;

  // y with the implicit y[-1]=0 appended; arithmetic shift keeps sign fill for the skip test.
  assign w_yext   = {r_y, 1'b0};
  assign w_ysh    = w_yext >>> {r_cnt, 1'b0};
  assign w_pp_ext = {{(WIDTH-2){w_pp[WIDTH+1]}}, w_pp};
  assign w_pp_sh  = w_pp_ext << {r_cnt, 1'b0};
  assign w_sum    = r_acc + w_pp_sh;
  assign w_last   = (r_cnt == CW'(NDIG - 1));

`ifdef BOOTH_SEQ_ZERO_SKIP_EN
  assign w_skip = (&w_ysh) | (~|w_ysh);
`else
  assign w_skip = 1'b0;
`endif

  booth_digit_pp #(.WIDTH(WIDTH)) u_pp (
    .i_y3 (w_ysh[2:0]),
    .i_x  (r_x),
    .o_pp (w_pp)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) w_next = ST_RUN;
        else          w_next = ST_IDLE;
      end
      ST_RUN: begin
        if (w_skip || w_last) w_next = ST_DONE;
        else                  w_next = ST_RUN;
      end
      ST_DONE: begin
        if (out_ready) w_next = ST_IDLE;
        else           w_next = ST_DONE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      ST_IDLE: in_ready = 1'b1;
      ST_RUN:  busy = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Operand capture, accumulation and product hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x   <= '0;
      r_y   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_p   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            r_x   <= in_x;
            r_y   <= in_y;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (w_skip) begin
            r_p <= r_acc;
          end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) r_p <= w_sum;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_p = r_p;

endmodule

// File: doc/booth_seq_ctrl.md
BOOTH_SEQ_CTRL -- requirements
Module: booth_seq_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits (even, >= 4).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operand pair offered.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: in_x  input  WIDTH  multiplicand, two's complement.
REQ-007 SHALL have port: in_y  input  WIDTH  multiplier, two's complement.
REQ-008 SHALL have port: out_valid  output  1  product available.
REQ-009 SHALL have port: out_ready  input  1  consumer takes product.
REQ-010 SHALL have port: out_p  output  2*WIDTH  signed product.
REQ-011 SHALL have port: busy  output  1  high in RUN or DONE.

Function
REQ-012 SHALL implement FSM with states IDLE, RUN, DONE.
REQ-013 SHALL assert in_ready only in IDLE; accept when in_valid && in_ready at a clock edge, latch in_x/in_y, clear accumulator and digit counter, enter RUN.
REQ-014 SHALL, in RUN cycle i (i = 0..WIDTH/2-1), recode bits {y[2i+1], y[2i], y[2i-1]} (y[-1] = 0) into a radix-4 digit in {-2,-1,0,+1,+2}.
REQ-015 SHALL form each partial product as digit*x in WIDTH+2 bits, sign-extend to 2*WIDTH, shift left by 2i, add to accumulator modulo 2^(2*WIDTH).
REQ-016 SHALL stay in RUN exactly WIDTH/2 cycles, then enter DONE; accept at cycle 0 gives out_valid high at cycle WIDTH/2+1 (cycle 5 for WIDTH=8).
REQ-017 SHALL, in DONE, hold out_valid=1 and out_p stable until out_valid && out_ready, then enter IDLE with out_valid=0 next cycle.
REQ-018 SHALL keep out_p holding the last product in IDLE; out_p is only meaningful while out_valid=1.
REQ-019 SHALL ignore in_valid in RUN and DONE; no operand queueing and no accept in the DONE-exit cycle.
REQ-020 SHALL produce the exact product for all operand pairs, including x = y = -2^(WIDTH-1).

Reset
REQ-021 SHALL, on rst=1 at a clock edge, force IDLE, out_valid=0, out_p=0, busy=0, in_ready=1, accumulator=0, counter=0.
REQ-022 SHALL discard any in-flight operation on reset in RUN or DONE; no out_valid pulse for it.
REQ-023 SHALL give rst priority over simultaneous in_valid or out_ready.

Configuration
REQ-024 SHALL support macro BOOTH_SEQ_ZERO_SKIP_EN.
REQ-025 With BOOTH_SEQ_ZERO_SKIP_EN defined: at the start of RUN cycle i, if y[WIDTH-1:2i-1] (with y[-1] = 0) is all-0 or all-1, add nothing and enter DONE next cycle; RUN therefore lasts 1 to WIDTH/2 cycles.
REQ-026 Without BOOTH_SEQ_ZERO_SKIP_EN: fixed latency per REQ-016; results identical in both builds.

Structure
REQ-027 SHALL place in shared package booth_seq_pkg: state enum typedef, digit-code typedef (one/two/neg fields), default WIDTH constant.
REQ-028 SHALL use one combinational sub-module booth_digit_pp: three y bits plus x in, WIDTH+2-bit partial product out.
REQ-029 SHALL keep the single adder, accumulator, counter and FSM in booth_seq_ctrl.

Verification
REQ-030 x=7, y=3 accepted at cycle 0, out_ready=1 -> out_p=0x0015, out_valid only at cycle 5 (no macro).
REQ-031 x=-128, y=-128 -> out_p=0x4000; x=-128, y=127 -> 0xC080; x=-1, y=-1 -> 0x0001.
REQ-032 out_ready=0 for 3 cycles in DONE with in_valid=1 and new operands -> out_p and out_valid stable, in_ready=0, new operands not taken.
REQ-033 rst=1 during 2nd RUN cycle -> next cycle state IDLE, out_valid=0, out_p=0, in_ready=1; next accepted 2*3 gives 0x0006.
REQ-034 Macro defined: x=5, y=0 -> out_valid at cycle 2, out_p=0; x=5, y=1 -> out_valid at cycle 3, out_p=0x0005; macro undefined -> both at cycle 5.
REQ-035 Random signed operands, 10k back-to-back transactions with random out_ready stalls -> every out_p equals the reference product; no lost or duplicated results.
